mmio_periph_bank: RTL and testbench
===================================

// Module: mmio_periph_bank
// PURPOSE
//  Parametrised memory-mapped peripheral bank for the RV32I core: N-channel PWM, microsecond/millisecond
//  timers, millisecond alarm. Decodes a word-aligned window at BASE_ADDR, sits beside the 8kB RAM on the
//  shared read/write address buses; core muxes read_data when rd_hit=1. Adds reset, wider PWM, glitch-free duty.
// PARAMETERS
//  BASE_ADDR  32'hFFFF_FF00  window base; 64-byte window, BASE_ADDR[5:0] must be 0
//  CLK_HZ     12_000_000     clk frequency; CLK_HZ/1_000_000 integer and >=2
//  NUM_PWM    4              PWM channels, 1..8
//  PWM_WIDTH  8              PWM counter bits, 4..16
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          async active-low reset
//  write_mem      in   1          write strobe, sampled on posedge clk
//  funct3         in   3          access size/sign: [1]=word, [0]=half, else byte; [2]=zero-extend reads
//  write_address  in   32         byte write address
//  write_data     in   32         write data, right-justified for byte/half
//  read_address   in   32         byte read address
//  read_data      out  32         read data, combinational; 0 when rd_hit=0
//  rd_hit         out  1          read_address inside window
//  pwm_out        out  NUM_PWM    active-high PWM outputs
//  irq            out  1          alarm_flag & irq_en
// BEHAVIOUR
//  Register map (offset from BASE_ADDR): 0x00 MICROS R; 0x04 MILLIS R; 0x08 CTRL: [0] alarm_flag R/W1C,
//   [1] irq_en R/W; 0x0C ALARM R/W; 0x10+4k DUTY[k] R/W, PWM_WIDTH+1 bits zero-extended, k<NUM_PWM.
//  Unmapped offsets/channels >=NUM_PWM: read 0, writes ignored. Writes to R registers ignored.
//  Reads: combinational from read_address; byte/half lane select and sign/zero extend per funct3 and
//   read_address[1:0] exactly as RAM reads. Writes: byte/half/word lane-merged into the target register,
//   effective next posedge; bits above register width dropped; misalignment ignores low address bits.
//  Reset (rst_n=0, async): micros, millis, prescalers, ALARM, CTRL, all DUTY, pwm counter = 0;
//   pwm_out=0, irq=0, read_data follows decode (reads 0 for all mapped regs). Mid-op reset aborts all.
//  Timebase: us_div counts 0..CLK_HZ/1e6-1; terminal count -> us_tick, micros+1 (wrap mod 2^32).
//   ms_div counts us_ticks 0..999; on its terminal us_tick -> ms_tick, millis+1 same cycle as micros+1.
//  Alarm: on ms_tick, if millis+1 == ALARM then alarm_flag<=1. Same-cycle set and W1C: set wins.
//  PWM: shared free-running counter 0..2^PWM_WIDTH-1, wraps. Each channel has shadow duty (written) and
//   active duty; active<=shadow only in the cycle counter wraps to 0 (no mid-period glitch).
//   pwm_out[k] = (counter < active[k]), registered (1-cycle output delay). active >= 2^PWM_WIDTH -> always on;
//   0 -> always off. DUTY reads return shadow value.
// CONFIGURATION
//  MMIO_ALARM_EN defined: ALARM, CTRL, irq behave as above.
//  MMIO_ALARM_EN undefined: no alarm logic; offsets 0x08/0x0C read 0, writes ignored; irq tied 0.
// STRUCTURE
//  Package mmio_periph_pkg: register offset localparams, CTRL bit indices, funct3 size enum
//   (SZ_BYTE/SZ_HALF/SZ_WORD), lane-merge and load-extend functions shared with memory.
//  Sub-module pwm_channel (one per channel via generate): shadow/active duty, compare, output flop;
//   counter and wrap strobe supplied by parent.
// TESTING
//  Reset: hold rst_n=0 mid-count -> all reads 0, pwm_out=0, irq=0; release -> MICROS=1 after 12 clks.
//  Timebase: run 12_000 clks -> MILLIS=1, MICROS=1000; force micros=32'hFFFF_FFFF -> wraps to 0.
//  PWM: sw DUTY0=0x40 -> takes effect at next wrap; pwm_out[0] high 64 of 256 cycles; DUTY0=0x100 always high.
//  Sub-word: sb 0xAB to DUTY1+0 then lb -> 32'hFFFF_FFAB, lbu -> 32'h0000_00AB; sh to MILLIS ignored.
//  Alarm (MMIO_ALARM_EN): ALARM=3, irq_en=1 -> irq rises on 3rd ms_tick; W1C same cycle as set -> flag stays 1.
//  Decode: read BASE_ADDR+0x30 with NUM_PWM=4 -> 0, rd_hit=1; BASE_ADDR-4 -> rd_hit=0, read_data=0.

Source files
------------

// File: rtl/mmio_periph_pkg.sv
// Shared register-map constants and RAM-compatible sub-word helpers for the peripheral bank.
// Lane merge and load extend follow the same byte/half/word rules as the core's data RAM.
package mmio_periph_pkg;

  localparam logic [5:0] OFF_MICROS = 6'h00;
  localparam logic [5:0] OFF_MILLIS = 6'h04;
  localparam logic [5:0] OFF_CTRL   = 6'h08;
  localparam logic [5:0] OFF_ALARM  = 6'h0C;
  localparam logic [5:0] OFF_DUTY0  = 6'h10;

  localparam int CTRL_FLAG   = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic size_e decode_size(input logic [1:0] f3_lo);
    if (f3_lo[1]) return SZ_WORD;
    if (f3_lo[0]) return SZ_HALF;
    return SZ_BYTE;
  endfunction

  function automatic logic [5:0] duty_off(input int k);
    return OFF_DUTY0 + 6'(4 * k);
  endfunction

  // Misaligned half/word stores drop the low address bits rather than faulting.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  addr_lo,
                                             input size_e       sz);
    logic [31:0] merged;
    merged = old_val;
    case (sz)
      SZ_WORD: merged = wdata;
      SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    endcase
    return merged;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  funct3);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = word[{addr_lo[1], 4'b0000} +: 16];
    byte_v = word[{addr_lo, 3'b000} +: 8];
    case (decode_size(funct3[1:0]))
      SZ_WORD: res = word;
      SZ_HALF: res = funct3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: res = funct3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mmio_periph_bank_if.sv
// Shared core data-bus view of the peripheral bank: one write port, one combinational read port.
interface mmio_periph_bank_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        rd_hit;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data, rd_hit
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data, rd_hit
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty written by software, active duty reloaded only on counter wrap.
// Output is registered, so pwm_out lags the compare by one clock.
module pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [PWM_WIDTH:0]   i_wr_dat,
  input  logic [PWM_WIDTH-1:0] i_cnt,
  input  logic                 i_wrap,
  output logic [PWM_WIDTH:0]   o_shadow,
  output logic                 o_pwm
);

  logic [PWM_WIDTH:0] r_shadow;
  logic [PWM_WIDTH:0] r_active;
  logic               r_pwm;

  // The extra duty bit lets 2^PWM_WIDTH and above hold the output high for the whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr_en) r_shadow <= i_wr_dat;
      if (i_wrap)  r_active <= r_shadow;
      r_pwm <= ({1'b0, i_cnt} < r_active);
    end
  end

  assign o_shadow = r_shadow;
  assign o_pwm    = r_pwm;

endmodule

// File: rtl/mmio_periph_bank.sv
// Memory-mapped microsecond/millisecond timebase, PWM bank and ms alarm (alarm built only with MMIO_ALARM_EN).
// Reads decode combinationally from read_address; writes take effect on the next clk edge.
module mmio_periph_bank
  import mmio_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          CLK_HZ    = 12_000_000,
  parameter int          NUM_PWM   = 4,
  parameter int          PWM_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_periph_bank_if.slave  bus,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);

  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  logic [US_W-1:0]      r_us_div;
  logic [9:0]           r_ms_div;
  logic [31:0]          r_micros;
  logic [31:0]          r_millis;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;

  logic w_us_tick;
  logic w_ms_tick;
  logic w_pwm_wrap;

  assign w_us_tick  = (r_us_div == US_W'(US_DIV - 1));
  assign w_ms_tick  = w_us_tick && (r_ms_div == 10'd999);
  assign w_pwm_wrap = &r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_us_div  <= '0;
      r_ms_div  <= '0;
      r_micros  <= '0;
      r_millis  <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_us_div  <= w_us_tick ? '0 : r_us_div + 1'b1;
      if (w_us_tick) begin
        r_micros <= r_micros + 32'd1;
        r_ms_div <= w_ms_tick ? '0 : r_ms_div + 1'b1;
        if (w_ms_tick) r_millis <= r_millis + 32'd1;
      end
    end
  end

  logic       w_wr_hit;
  logic [5:0] w_wr_off;
  size_e      w_wr_sz;

  assign w_wr_hit = bus.write_mem && (bus.write_address[31:6] == BASE_ADDR[31:6]);
  assign w_wr_off = {bus.write_address[5:2], 2'b00};
  assign w_wr_sz  = decode_size(bus.funct3[1:0]);

  logic [PWM_WIDTH:0] w_shadow [NUM_PWM];

  for (genvar k = 0; k < NUM_PWM; k++) begin : g_pwm
    logic [31:0] w_duty_m;
    logic        w_unused_duty;

    assign w_duty_m      = lane_merge(32'(w_shadow[k]), bus.write_data,
                                      bus.write_address[1:0], w_wr_sz);
    assign w_unused_duty = ^w_duty_m[31:PWM_WIDTH+1];

    pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_en  (w_wr_hit && (w_wr_off == duty_off(k))),
      .i_wr_dat (w_duty_m[PWM_WIDTH:0]),
      .i_cnt    (r_pwm_cnt),
      .i_wrap   (w_pwm_wrap),
      .o_shadow (w_shadow[k]),
      .o_pwm    (pwm_out[k])
    );
  end

`ifdef MMIO_ALARM_EN
  logic [31:0] r_alarm;
  logic        r_flag;
  logic        r_irq_en;
  logic [31:0] w_ctrl_m;
  logic [31:0] w_alarm_m;
  logic        w_alarm_set;
  logic        w_ctrl_wr;
  logic        w_unused_ctrl;

  assign w_ctrl_m      = lane_merge({30'h0, r_irq_en, r_flag}, bus.write_data,
                                    bus.write_address[1:0], w_wr_sz);
  assign w_alarm_m     = lane_merge(r_alarm, bus.write_data, bus.write_address[1:0], w_wr_sz);
  assign w_ctrl_wr     = w_wr_hit && (w_wr_off == OFF_CTRL);
  assign w_alarm_set   = w_ms_tick && ((r_millis + 32'd1) == r_alarm);
  assign w_unused_ctrl = ^w_ctrl_m[31:2];

  // A hardware set in the same cycle as a software clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm  <= '0;
      r_flag   <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr_hit && (w_wr_off == OFF_ALARM)) r_alarm <= w_alarm_m;
      if (w_ctrl_wr) r_irq_en <= w_ctrl_m[CTRL_IRQ_EN];
      if (w_alarm_set)                          r_flag <= 1'b1;
      else if (w_ctrl_wr && w_ctrl_m[CTRL_FLAG]) r_flag <= 1'b0;
    end
  end

  assign irq = r_flag & r_irq_en;
`else
  assign irq = 1'b0;
`endif

  logic       w_rd_hit;
  logic [5:0] w_rd_off;
  logic [31:0] w_rd_word;

  assign w_rd_hit = (bus.read_address[31:6] == BASE_ADDR[31:6]);
  assign w_rd_off = {bus.read_address[5:2], 2'b00};

  always_comb begin
    w_rd_word = '0;
    case (w_rd_off)
      OFF_MICROS: w_rd_word = r_micros;
      OFF_MILLIS: w_rd_word = r_millis;
`ifdef MMIO_ALARM_EN
      OFF_CTRL:   w_rd_word = {30'h0, r_irq_en, r_flag};
      OFF_ALARM:  w_rd_word = r_alarm;
`endif
      default: begin
        for (int k = 0; k < NUM_PWM; k++) begin
          if (w_rd_off == duty_off(k)) w_rd_word = 32'(w_shadow[k]);
        end
      end
    endcase
  end

  assign bus.rd_hit    = w_rd_hit;
  assign bus.read_data = w_rd_hit ? load_extend(w_rd_word, bus.read_address[1:0], bus.funct3)
                                  : 32'h0;

endmodule

// File: tb/tb_mmio_periph_bank.sv
// Randomised and directed bench for mmio_periph_bank, checked every cycle against a cycle-count model.
module tb_mmio_periph_bank;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int NPWM = 4;

  logic clk;
  logic rst_n;
  logic [NPWM-1:0] pwm_out;
  logic irq;

  mmio_periph_bank_if bus();

  mmio_periph_bank #(
    .BASE_ADDR (BASE),
    .CLK_HZ    (12_000_000),
    .NUM_PWM   (NPWM),
    .PWM_WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Model state: everything derives from the number of clock edges since reset release.
  longint unsigned m_n;
  logic [8:0]      m_shadow [NPWM];
  logic [8:0]      m_active [NPWM];
  logic [NPWM-1:0] m_pwm;
  logic            m_flag;
  logic            m_irq_en;
  logic [31:0]     m_alarm;

  function automatic logic [31:0] m_micros();
    return 32'(m_n / 12);
  endfunction

  function automatic logic [31:0] m_millis();
    return 32'(m_n / 12000);
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a & 32'hFFFF_FFC0) == BASE;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] a, input logic [2:0] f3);
    logic [3:0]  be;
    logic [31:0] sd;
    logic [31:0] r;
    if (f3[1]) begin
      be = 4'hF; sd = d;
    end else if (f3[0]) begin
      be = a[1] ? 4'hC : 4'h3; sd = a[1] ? (d << 16) : d;
    end else begin
      be = 4'b0001 << a[1:0]; sd = d << (8 * a[1:0]);
    end
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? sd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_reg(input logic [31:0] a);
    int idx;
    if (!in_win(a)) return 32'h0;
    idx = int'(a[5:2]);
    if (idx == 0) return m_micros();
    if (idx == 1) return m_millis();
`ifdef MMIO_ALARM_EN
    if (idx == 2) return {30'h0, m_irq_en, m_flag};
    if (idx == 3) return m_alarm;
`endif
    if (idx >= 4 && idx < 4 + NPWM) return {23'h0, m_shadow[idx-4]};
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = m_reg(a);
    if (f3[1]) return w;
    if (f3[0]) begin
      h = 16'(w >> (a[1] ? 16 : 0));
      return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
    end
    b = 8'(w >> (8 * a[1:0]));
    return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_flag = 1'b0; m_irq_en = 1'b0; m_alarm = 32'h0; m_pwm = '0;
      for (int k = 0; k < NPWM; k++) begin
        m_shadow[k] = 9'h0;
        m_active[k] = 9'h0;
      end
    end else begin
      int          cnt_prev;
      int          idx;
      logic        set_now;
      logic [31:0] mv;
      cnt_prev = int'(m_n % 256);
      for (int k = 0; k < NPWM; k++) m_pwm[k] = (cnt_prev < int'(m_active[k]));
      if (cnt_prev == 255)
        for (int k = 0; k < NPWM; k++) m_active[k] = m_shadow[k];
      m_n = m_n + 1;
      set_now = 1'b0;
`ifdef MMIO_ALARM_EN
      set_now = (m_n % 12000 == 0) && (m_millis() == m_alarm);
`endif
      if (bus.write_mem && in_win(bus.write_address)) begin
        idx = int'(bus.write_address[5:2]);
`ifdef MMIO_ALARM_EN
        if (idx == 2) begin
          mv = m_merge({30'h0, m_irq_en, m_flag}, bus.write_data, bus.write_address, bus.funct3);
          m_irq_en = mv[1];
          if (mv[0]) m_flag = 1'b0;
        end
        if (idx == 3) m_alarm = m_merge(m_alarm, bus.write_data, bus.write_address, bus.funct3);
`endif
        if (idx >= 4 && idx < 4 + NPWM) begin
          mv = m_merge({23'h0, m_shadow[idx-4]}, bus.write_data, bus.write_address, bus.funct3);
          m_shadow[idx-4] = mv[8:0];
        end
      end
      if (set_now) m_flag = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_hit", 32'(bus.rd_hit), 32'(in_win(bus.read_address)));
      check("read_data", bus.read_data, m_read(bus.read_address, bus.funct3));
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("irq", 32'(irq), 32'(m_flag & m_irq_en));
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.write_mem = 1'b1; bus.write_address = a; bus.write_data = d; bus.funct3 = f3;
    @(posedge clk); #1;
    bus.write_mem = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] v, output logic h);
    bus.read_address = a; bus.funct3 = f3;
    @(negedge clk);
    v = bus.read_data; h = bus.rd_hit;
    @(posedge clk); #1;
  endtask

  // Counts pwm_out[0] over one full period that starts with the newly loaded active duty.
  task automatic pwm_period(output int cnt);
    int guard;
    tick(2);
    guard = 0;
    while ((m_n % 256) != 1 && guard < 300) begin
      tick(1); guard++;
    end
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cnt += int'(pwm_out[0]);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE - 32'd4;
    if (r == 1) return $urandom();
    return BASE + 32'($urandom_range(0, 63));
  endfunction

  logic [31:0] v;
  logic        h;
  int          cnt;
  int          guard;

  initial begin
    rst_n = 1'b0;
    bus.write_mem = 1'b0; bus.funct3 = 3'b010;
    bus.write_address = 32'h0; bus.write_data = 32'h0; bus.read_address = BASE;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset in the middle of counting with a PWM output running.
    tick(40);
    wr(BASE + 32'h10, 32'h20, 3'b010);
    tick(300);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rd(BASE + 32'h0, 3'b010, v, h);  check("reset_micros", v, 32'h0);
    rd(BASE + 32'h10, 3'b010, v, h); check("reset_duty0", v, 32'h0);
    rst_n = 1'b1;

    // Timebase: first microsecond after 12 clocks, first millisecond after 12000.
    tick(11);
    rd(BASE + 32'h0, 3'b010, v, h); check("micros_11clk", v, 32'd0);
    rd(BASE + 32'h0, 3'b010, v, h); check("micros_12clk", v, 32'd1);
    tick(12000 - 13);
    rd(BASE + 32'h0, 3'b010, v, h); check("micros_12000clk", v, 32'd1000);
    rd(BASE + 32'h4, 3'b010, v, h); check("millis_12000clk", v, 32'd1);
    check("model_millis", m_millis(), 32'd1);

    // PWM duty 0x40 -> 64 of 256, 0x100 -> always on.
    wr(BASE + 32'h10, 32'h40, 3'b010);
    pwm_period(cnt); check("pwm_duty_40", 32'(cnt), 32'd64);
    wr(BASE + 32'h10, 32'h100, 3'b010);
    pwm_period(cnt); check("pwm_duty_100", 32'(cnt), 32'd256);
    rd(BASE + 32'h10, 3'b010, v, h); check("duty0_readback", v, 32'h100);

    // Sub-word access.
    wr(BASE + 32'h14, 32'hAB, 3'b000);
    rd(BASE + 32'h14, 3'b000, v, h); check("lb_duty1", v, 32'hFFFF_FFAB);
    rd(BASE + 32'h14, 3'b100, v, h); check("lbu_duty1", v, 32'h0000_00AB);
    wr(BASE + 32'h4, 32'h1234, 3'b001);
    rd(BASE + 32'h4, 3'b010, v, h); check("sh_millis_ignored", v, m_millis());

    // Decode edges.
    rd(BASE + 32'h30, 3'b010, v, h);
    check("unmapped_data", v, 32'h0); check("unmapped_hit", 32'(h), 32'h1);
    rd(BASE - 32'd4, 3'b010, v, h);
    check("below_data", v, 32'h0); check("below_hit", 32'(h), 32'h0);

    // Random traffic with a reset pulse in the middle.
    for (int i = 0; i < 3000; i++) begin
      bus.write_mem     = 1'($urandom_range(0, 1));
      bus.write_address = rand_addr();
      bus.write_data    = $urandom();
      bus.funct3        = 3'($urandom_range(0, 7));
      bus.read_address  = rand_addr();
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    bus.write_mem = 1'b0;

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
`ifdef MMIO_ALARM_EN
    wr(BASE + 32'hC, 32'd3, 3'b010);
    wr(BASE + 32'h8, 32'h2, 3'b010);
    bus.read_address = BASE + 32'h8;
    for (guard = 0; guard < 40000; guard++) begin
      @(negedge clk);
      if (irq) break;
      @(posedge clk); #1;
    end
    check("alarm_irq_cycle", 32'(m_n), 32'd36000);
    @(posedge clk); #1;
    wr(BASE + 32'h8, 32'h3, 3'b010);
    rd(BASE + 32'h8, 3'b010, v, h); check("ctrl_after_w1c", v, 32'h2);
    wr(BASE + 32'hC, 32'd4, 3'b010);
    guard = 0;
    while (m_n < 47999 && guard < 20000) begin
      tick(1); guard++;
    end
    wr(BASE + 32'h8, 32'h3, 3'b010);
    rd(BASE + 32'h8, 3'b010, v, h); check("set_beats_w1c", v, 32'h3);
    check("irq_after_set", 32'(irq), 32'h1);
`else
    wr(BASE + 32'hC, 32'd3, 3'b010);
    wr(BASE + 32'h8, 32'h3, 3'b010);
    rd(BASE + 32'h8, 3'b010, v, h); check("ctrl_absent", v, 32'h0);
    rd(BASE + 32'hC, 3'b010, v, h); check("alarm_absent", v, 32'h0);
    check("irq_absent", 32'(irq), 32'h0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
